reg_file_sb: RTL and testbench

Parametrised integer register file with a pending-write scoreboard for the Primitive-RISC-V core. It provides two combinational read ports, one write port, optional write-to-read bypass and per-register busy bits. The busy bits are set when a long-latency producer such as a load issues, and cleared at its writeback. It sits between decode (read/issue) and writeback, and drives the decode stall for RAW hazards on pending results.

---
 rtl/reg_file_sb.sv | 97 +++++++++
 tb/tb_reg_file_sb.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with two combinational read ports, one
// write port, optional same-cycle write-to-read bypass, and a pending-write
// scoreboard (one busy bit per register) that drives the decode RAW stall.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(NREG) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            use1,
  input  logic            use2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            mark_en,
  input  logic [AW-1:0]   mark_a,
  output logic            busy1,
  output logic            busy2,
  output logic            stall,
  output logic [CW-1:0]   pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [CW-1:0]   pend_next;
  logic            wr_hit;
  logic            mk_hit;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            byp1;
  logic            byp2;

  // x0 is hardwired, so writes and marks aimed at it are dropped here
  assign wr_hit = we3 && (a3 != '0);
  assign mk_hit = mark_en && (mark_a != '0);

  // Next scoreboard state: a writeback clears, a mark sets, and the mark wins
  // on a same-address collision because the new producer is younger
  always_comb begin
    busy_next = busy;
    if (wr_hit) busy_next[a3] = 1'b0;
    if (mk_hit) busy_next[mark_a] = 1'b1;
    cnt_inc   = mk_hit && !busy[mark_a];
    cnt_dec   = wr_hit && busy[a3] && !(mk_hit && (mark_a == a3));
    pend_next = pend_cnt + CW'(cnt_inc) - CW'(cnt_dec);
  end

  // Register storage, cleared asynchronously so a reset loses all state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[a3] <= wd3;
    end
  end

  // Busy bits and their running popcount, kept in step on every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_next;
      pend_cnt <= pend_next;
    end
  end

  // Read port 1: x0 reads zero; a same-cycle writeback forwards when bypassing
  always_comb begin
    byp1 = (BYPASS != 0) && we3 && (a3 == a1) && (a1 != '0);
    if (a1 == '0)  rd1 = '0;
    else if (byp1) rd1 = wd3;
    else           rd1 = regs[a1];
    busy1 = busy[a1] && !byp1;
  end

  // Read port 2: same rules as port 1
  always_comb begin
    byp2 = (BYPASS != 0) && we3 && (a3 == a2) && (a2 != '0);
    if (a2 == '0)  rd2 = '0;
    else if (byp2) rd2 = wd3;
    else           rd2 = regs[a2];
    busy2 = busy[a2] && !byp2;
  end

  // Decode stalls only on operands it actually consumes this cycle
  assign stall = (use1 && busy1) || (use2 && busy2);

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed tests for reg_file_sb; a BYPASS=0 instance shares
// all inputs so the non-bypassed read behaviour can be checked side by side.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1, a2, a3, mark_a;
  logic        use1, use2, we3, mark_en;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, stall, busy1_nb, busy2_nb, stall_nb;
  logic [5:0]  pend_cnt, pend_nb;

  int checks;
  int errors;

  reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .use1(use1), .use2(use2), .we3(we3), .a3(a3), .wd3(wd3),
    .mark_en(mark_en), .mark_a(mark_a), .busy1(busy1), .busy2(busy2),
    .stall(stall), .pend_cnt(pend_cnt)
  );

  reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1_nb), .rd2(rd2_nb),
    .use1(use1), .use2(use2), .we3(we3), .a3(a3), .wd3(wd3),
    .mark_en(mark_en), .mark_a(mark_a), .busy1(busy1_nb), .busy2(busy2_nb),
    .stall(stall_nb), .pend_cnt(pend_nb)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Return every input to its inactive value
  task automatic idle();
    a1 = '0; a2 = '0; a3 = '0; mark_a = '0;
    use1 = 1'b0; use2 = 1'b0; we3 = 1'b0; mark_en = 1'b0; wd3 = '0;
  endtask

  // Reset values, all-zero reads, and x0 immunity to writes and marks
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("[TB] FAIL reset_pend: got %0d expected 0", pend_cnt); end
    checks++; if (rd1 !== 32'd0 || busy1 !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_outs: rd1=%h busy1=%b stall=%b expected 0/0/0", rd1, busy1, stall); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); a1 = 5'(i); a2 = 5'(31 - i); #1;
      checks++; if (rd1 !== 32'd0 || rd2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_read[%0d]: rd1=%h rd2=%h expected 0", i, rd1, rd2); end
    end
    @(negedge clk); idle(); we3 = 1'b1; a3 = 5'd0; wd3 = 32'hDEADBEEF; a1 = 5'd0; #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("[TB] FAIL x0_bypass: got %h expected 0", rd1); end
    @(negedge clk); we3 = 1'b0; mark_en = 1'b1; mark_a = 5'd0; #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("[TB] FAIL x0_write: got %h expected 0", rd1); end
    @(negedge clk); mark_en = 1'b0; use1 = 1'b1; #1;
    checks++; if (pend_cnt !== 6'd0 || busy1 !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL x0_mark: pend=%0d busy1=%b stall=%b expected 0/0/0", pend_cnt, busy1, stall); end
  endtask

  // Plain write followed by reads on both ports
  task automatic test_write_read();
    @(negedge clk); idle(); we3 = 1'b1; a3 = 5'd5; wd3 = 32'h12345678;
    @(negedge clk); idle(); a1 = 5'd5; a2 = 5'd5; #1;
    checks++; if (rd1 !== 32'h12345678 || rd2 !== 32'h12345678) begin errors++; $display("[TB] FAIL write_read: rd1=%h rd2=%h expected 12345678", rd1, rd2); end
    checks++; if (rd1_nb !== 32'h12345678 || rd2_nb !== 32'h12345678) begin errors++; $display("[TB] FAIL write_read_nb: rd1=%h rd2=%h expected 12345678", rd1_nb, rd2_nb); end
  endtask

  // Same-cycle write visibility with and without bypass
  task automatic test_bypass();
    @(negedge clk); idle(); we3 = 1'b1; a3 = 5'd7; wd3 = 32'd1;
    @(negedge clk); idle(); we3 = 1'b1; a3 = 5'd7; wd3 = 32'hA5A5A5A5; a1 = 5'd7; a2 = 5'd5; #1;
    checks++; if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL bypass_on: got %h expected a5a5a5a5", rd1); end
    checks++; if (rd1_nb !== 32'd1) begin errors++; $display("[TB] FAIL bypass_off: got %h expected 00000001", rd1_nb); end
    checks++; if (rd2 !== 32'h12345678) begin errors++; $display("[TB] FAIL bypass_other_port: got %h expected 12345678", rd2); end
    @(negedge clk); we3 = 1'b0; #1;
    checks++; if (rd1 !== 32'hA5A5A5A5 || rd1_nb !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL bypass_next: rd1=%h rd1_nb=%h expected a5a5a5a5", rd1, rd1_nb); end
  endtask

  // Load-use hazard: mark, stall, writeback clears the stall
  task automatic test_load_use();
    @(negedge clk); idle(); mark_en = 1'b1; mark_a = 5'd9;
    @(negedge clk); idle(); a1 = 5'd9; use1 = 1'b1; #1;
    checks++; if (stall !== 1'b1 || busy1 !== 1'b1 || pend_cnt !== 6'd1) begin errors++; $display("[TB] FAIL load_use_stall: stall=%b busy1=%b pend=%0d expected 1/1/1", stall, busy1, pend_cnt); end
    @(negedge clk); we3 = 1'b1; a3 = 5'd9; wd3 = 32'h99; #1;
    checks++; if (stall !== 1'b0 || busy1 !== 1'b0 || rd1 !== 32'h99) begin errors++; $display("[TB] FAIL load_use_wb: stall=%b busy1=%b rd1=%h expected 0/0/99", stall, busy1, rd1); end
    checks++; if (stall_nb !== 1'b1 || busy1_nb !== 1'b1) begin errors++; $display("[TB] FAIL load_use_wb_nb: stall=%b busy1=%b expected 1/1", stall_nb, busy1_nb); end
    @(negedge clk); we3 = 1'b0; #1;
    checks++; if (stall !== 1'b0 || pend_cnt !== 6'd0 || pend_nb !== 6'd0) begin errors++; $display("[TB] FAIL load_use_done: stall=%b pend=%0d pend_nb=%0d expected 0/0/0", stall, pend_cnt, pend_nb); end
  endtask

  // Marks and writebacks landing on the same edge
  task automatic test_simultaneous();
    @(negedge clk); idle(); mark_en = 1'b1; mark_a = 5'd3; we3 = 1'b1; a3 = 5'd3; wd3 = 32'h33;
    @(negedge clk); idle(); a1 = 5'd3; #1;
    checks++; if (busy1 !== 1'b1 || rd1 !== 32'h33 || pend_cnt !== 6'd1) begin errors++; $display("[TB] FAIL same_addr: busy1=%b rd1=%h pend=%0d expected 1/33/1", busy1, rd1, pend_cnt); end
    mark_en = 1'b1; mark_a = 5'd6;
    @(negedge clk); idle(); mark_en = 1'b1; mark_a = 5'd4; we3 = 1'b1; a3 = 5'd6; wd3 = 32'h66; #1;
    checks++; if (pend_cnt !== 6'd2) begin errors++; $display("[TB] FAIL mark6: got %0d expected 2", pend_cnt); end
    @(negedge clk); idle(); a1 = 5'd4; a2 = 5'd6; use1 = 1'b1; use2 = 1'b1; #1;
    checks++; if (pend_cnt !== 6'd2 || busy1 !== 1'b1 || busy2 !== 1'b0 || busy2_nb !== 1'b0) begin errors++; $display("[TB] FAIL mark_clear: pend=%0d busy1=%b busy2=%b expected 2/1/0", pend_cnt, busy1, busy2); end
    checks++; if (rd2 !== 32'h66 || rd2_nb !== 32'h66 || stall !== 1'b1) begin errors++; $display("[TB] FAIL mark_clear_data: rd2=%h stall=%b expected 66/1", rd2, stall); end
    mark_en = 1'b1; mark_a = 5'd3;
    @(negedge clk); idle(); we3 = 1'b1; a3 = 5'd5; wd3 = 32'h55;
    @(negedge clk); idle(); #1;
    checks++; if (pend_cnt !== 6'd2) begin errors++; $display("[TB] FAIL remark_nonbusy_write: got %0d expected 2", pend_cnt); end
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); mark_en = 1'b1; mark_a = 5'(i);
    end
    @(negedge clk); idle(); a1 = 5'd31; a2 = 5'd17; #1;
    checks++; if (pend_cnt !== 6'd31 || busy1 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("[TB] FAIL mark_all: pend=%0d busy1=%b busy2=%b expected 31/1/1", pend_cnt, busy1, busy2); end
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); we3 = 1'b1; a3 = 5'(i); wd3 = 32'(i);
    end
    @(negedge clk); idle(); a1 = 5'd31; a2 = 5'd17; #1;
    checks++; if (pend_cnt !== 6'd0 || rd1 !== 32'd31 || rd2 !== 32'd17) begin errors++; $display("[TB] FAIL clear_all: pend=%0d rd1=%h rd2=%h expected 0/1f/11", pend_cnt, rd1, rd2); end
  endtask

  // Asynchronous reset pulse between clock edges wipes data and scoreboard
  task automatic test_reset_mid();
    @(negedge clk); idle(); we3 = 1'b1; a3 = 5'd10; wd3 = 32'h55;
    @(negedge clk); idle(); mark_en = 1'b1; mark_a = 5'd1;
    @(negedge clk); mark_a = 5'd2;
    @(negedge clk); mark_a = 5'd10;
    @(negedge clk); mark_a = 5'd20;
    @(negedge clk); idle(); a1 = 5'd10; a2 = 5'd20; use1 = 1'b1; use2 = 1'b1; #1;
    checks++; if (pend_cnt !== 6'd4 || stall !== 1'b1 || rd1 !== 32'h55) begin errors++; $display("[TB] FAIL pre_reset: pend=%0d stall=%b rd1=%h expected 4/1/55", pend_cnt, stall, rd1); end
    #1; rst_n = 1'b0; #1;
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0 || stall !== 1'b0 || rd1 !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset: busy1=%b busy2=%b stall=%b rd1=%h expected 0/0/0/0", busy1, busy2, stall, rd1); end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("[TB] FAIL mid_reset_pend: got %0d expected 0", pend_cnt); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (pend_cnt !== 6'd0 || rd1 !== 32'd0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL post_reset: pend=%0d rd1=%h stall=%b expected 0/0/0", pend_cnt, rd1, stall); end
  endtask

  // Run every scenario in order, then report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_load_use();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
